// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - EX-stage ALU with iterative MULU and optional DIVU/REMU
// Define EX_MULDIV_DIVIDER_EN to build the restoring divider for DIVU/REMU.
module ex_muldiv_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        EX_valid,
   input  logic [4:0]  EX_ALU_OP,
   input  logic [31:0] EX_muxA,
   input  logic [31:0] EX_muxB,
   input  logic [15:0] EX_IMMEDIATE,
   input  logic        EX_ret_enable,
   input  logic [1:0]  EX_RF_D_SEL,
   input  logic        EX_DM_WE,
   input  logic        EX_DM_ADDR_SEL,
   output logic        EX_stall,
   output logic        MEM_valid,
   output logic [31:0] MEM_result,
   output logic [31:0] MEM_store_data,
   output logic        MEM_ret_enable,
   output logic [1:0]  MEM_RF_D_SEL,
   output logic        MEM_DM_WE,
   output logic        MEM_DM_ADDR_SEL
);
   localparam logic [4:0] OP_ADD  = 5'h00;
   localparam logic [4:0] OP_SUB  = 5'h01;
   localparam logic [4:0] OP_AND  = 5'h02;
   localparam logic [4:0] OP_OR   = 5'h03;
   localparam logic [4:0] OP_XOR  = 5'h04;
   localparam logic [4:0] OP_SLL  = 5'h05;
   localparam logic [4:0] OP_SRL  = 5'h06;
   localparam logic [4:0] OP_ADDI = 5'h08;
   localparam logic [4:0] OP_MULU = 5'h10;
`ifdef EX_MULDIV_DIVIDER_EN
   localparam logic [4:0] OP_DIVU = 5'h11;
   localparam logic [4:0] OP_REMU = 5'h12;
`endif

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, op_q, sb_q;
   logic [31:0] acc_q, opa_q, opb_q, store_q;
   logic [31:0] acc_d, opa_d, opb_d, fin_result, alu_result;
   logic        is_multi;

`ifdef EX_MULDIV_DIVIDER_EN
   logic [32:0] rem_shift, rem_sub;
   assign is_multi   = (EX_ALU_OP == OP_MULU) || (EX_ALU_OP == OP_DIVU) || (EX_ALU_OP == OP_REMU);
   assign fin_result = (op_q == OP_DIVU) ? opa_d : acc_d;
`else
   assign is_multi   = (EX_ALU_OP == OP_MULU);
   assign fin_result = acc_d;
`endif

   always_comb begin
      alu_result = 32'h0;
      case (EX_ALU_OP)
         OP_ADD:  alu_result = EX_muxA + EX_muxB;
         OP_SUB:  alu_result = EX_muxA - EX_muxB;
         OP_AND:  alu_result = EX_muxA & EX_muxB;
         OP_OR:   alu_result = EX_muxA | EX_muxB;
         OP_XOR:  alu_result = EX_muxA ^ EX_muxB;
         OP_SLL:  alu_result = EX_muxA << EX_muxB[4:0];
         OP_SRL:  alu_result = EX_muxA >> EX_muxB[4:0];
         OP_ADDI: alu_result = EX_muxA + {{16{EX_IMMEDIATE[15]}}, EX_IMMEDIATE};
         default: alu_result = 32'h0;
      endcase
   end

   // MULU: acc += multiplicand when multiplier LSB set. DIVU/REMU: acc is the
   // partial remainder, opa shifts dividend bits out and quotient bits in.
   always_comb begin
      acc_d = acc_q;
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
`ifdef EX_MULDIV_DIVIDER_EN
      rem_shift = {acc_q, opa_q[31]};
      rem_sub   = rem_shift - {1'b0, opb_q};
`endif
      if (op_q == OP_MULU) begin
         if (opb_q[0]) acc_d = acc_q + opa_q;
      end
`ifdef EX_MULDIV_DIVIDER_EN
      else begin
         opb_d = opb_q;
         if (!rem_sub[32]) begin
            acc_d = rem_sub[31:0];
            opa_d = {opa_q[30:0], 1'b1};
         end else begin
            acc_d = rem_shift[31:0];
            opa_d = {opa_q[30:0], 1'b0};
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      EX_stall = 1'b0;
      case (state_q)
         IDLE: begin
            if (EX_valid && is_multi) begin
               state_d  = ITER;
               EX_stall = 1'b1;
            end
         end
         ITER: begin
            EX_stall = 1'b1;
            if (cnt_q == 5'd31) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (!rst_n) EX_stall = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q           <= 5'd0;
         op_q            <= 5'd0;
         sb_q            <= 5'd0;
         acc_q           <= 32'h0;
         opa_q           <= 32'h0;
         opb_q           <= 32'h0;
         store_q         <= 32'h0;
         MEM_valid       <= 1'b0;
         MEM_result      <= 32'h0;
         MEM_store_data  <= 32'h0;
         MEM_ret_enable  <= 1'b0;
         MEM_RF_D_SEL    <= 2'b00;
         MEM_DM_WE       <= 1'b0;
         MEM_DM_ADDR_SEL <= 1'b0;
      end else begin
         MEM_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (EX_valid && is_multi) begin
                  cnt_q   <= 5'd0;
                  op_q    <= EX_ALU_OP;
                  acc_q   <= 32'h0;
                  opa_q   <= EX_muxA;
                  opb_q   <= EX_muxB;
                  store_q <= EX_muxB;
                  sb_q    <= {EX_ret_enable, EX_RF_D_SEL, EX_DM_WE, EX_DM_ADDR_SEL};
               end else if (EX_valid) begin
                  MEM_valid      <= 1'b1;
                  MEM_result     <= alu_result;
                  MEM_store_data <= EX_muxB;
                  {MEM_ret_enable, MEM_RF_D_SEL, MEM_DM_WE, MEM_DM_ADDR_SEL} <=
                     {EX_ret_enable, EX_RF_D_SEL, EX_DM_WE, EX_DM_ADDR_SEL};
               end
            end
            ITER: begin
               acc_q <= acc_d;
               opa_q <= opa_d;
               opb_q <= opb_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  MEM_valid      <= 1'b1;
                  MEM_result     <= fin_result;
                  MEM_store_data <= store_q;
                  {MEM_ret_enable, MEM_RF_D_SEL, MEM_DM_WE, MEM_DM_ADDR_SEL} <= sb_q;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        EX_valid;
   logic [4:0]  EX_ALU_OP;
   logic [31:0] EX_muxA, EX_muxB;
   logic [15:0] EX_IMMEDIATE;
   logic        EX_ret_enable, EX_DM_WE, EX_DM_ADDR_SEL;
   logic [1:0]  EX_RF_D_SEL;
   logic        EX_stall, MEM_valid;
   logic [31:0] MEM_result, MEM_store_data;
   logic        MEM_ret_enable, MEM_DM_WE, MEM_DM_ADDR_SEL;
   logic [1:0]  MEM_RF_D_SEL;
   logic [4:0]  mem_sb;

   int tests_run    = 0;
   int tests_failed = 0;

   ex_muldiv_unit dut (
      .clk(clk), .rst_n(rst_n), .EX_valid(EX_valid), .EX_ALU_OP(EX_ALU_OP),
      .EX_muxA(EX_muxA), .EX_muxB(EX_muxB), .EX_IMMEDIATE(EX_IMMEDIATE),
      .EX_ret_enable(EX_ret_enable), .EX_RF_D_SEL(EX_RF_D_SEL), .EX_DM_WE(EX_DM_WE),
      .EX_DM_ADDR_SEL(EX_DM_ADDR_SEL), .EX_stall(EX_stall), .MEM_valid(MEM_valid),
      .MEM_result(MEM_result), .MEM_store_data(MEM_store_data),
      .MEM_ret_enable(MEM_ret_enable), .MEM_RF_D_SEL(MEM_RF_D_SEL),
      .MEM_DM_WE(MEM_DM_WE), .MEM_DM_ADDR_SEL(MEM_DM_ADDR_SEL)
   );

   always #5 clk = ~clk;
   assign mem_sb = {MEM_ret_enable, MEM_RF_D_SEL, MEM_DM_WE, MEM_DM_ADDR_SEL};

   // ADD, SUB, AND, 0x07, OR, XOR, SRL, 0x1F, ADDI, SLL
   logic [4:0]  sc_op  [10] = '{5'h00, 5'h01, 5'h02, 5'h07, 5'h03, 5'h04, 5'h06, 5'h1F, 5'h08, 5'h05};
   logic [31:0] sc_a   [10] = '{32'h7FFFFFFF, 32'h5, 32'hF0F0F0F0, 32'h5, 32'hF0F0F0F0,
                                32'hFFFF0000, 32'h80000000, 32'h12345678, 32'h10, 32'h1};
   logic [31:0] sc_b   [10] = '{32'h1, 32'h7, 32'hFF00FF00, 32'h5, 32'h0F0F0000,
                                32'h0F0F0F0F, 32'hFFFFFFFF, 32'h9ABCDEF0, 32'hAAAA5555, 32'h25};
   logic [15:0] sc_imm [10] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h0};
   logic [31:0] sc_exp [10] = '{32'h80000000, 32'hFFFFFFFE, 32'hF000F000, 32'h0, 32'hFFFFF0F0,
                                32'hF0F00F0F, 32'h1, 32'h0, 32'hFFFF8010, 32'h20};

   task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] imm, input logic [4:0] sb);
      EX_valid     = v;
      EX_ALU_OP    = op;
      EX_muxA      = a;
      EX_muxB      = b;
      EX_IMMEDIATE = imm;
      {EX_ret_enable, EX_RF_D_SEL, EX_DM_WE, EX_DM_ADDR_SEL} = sb;
   endtask

   // Called at a negedge with the DUT in IDLE; returns at the negedge where MEM_valid is seen.
   task automatic run_multi(input string tag, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] sb, input logic [31:0] expected);
      int lat;
      int stalls;
      drive(1'b1, op, a, b, 16'h0, sb);
      #1;
      check_eq({tag, "_stall_same_cycle"}, 32'(EX_stall), 32'd1);
      stalls = 32'(EX_stall);
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         if (MEM_valid) break;
         stalls += 32'(EX_stall);
         lat++;
      end
      check_eq({tag, "_latency"}, 32'(lat), 32'd32);
      check_eq({tag, "_stall_cycles"}, 32'(stalls), 32'd33);
      check_eq({tag, "_result"}, MEM_result, expected);
      check_eq({tag, "_stall_done"}, 32'(EX_stall), 32'd0);
      check_eq({tag, "_store"}, MEM_store_data, b);
      check_eq({tag, "_sideband"}, 32'(mem_sb), 32'(sb));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      logic [4:0] sb_i;
      rst_n = 1'b0;
      drive(1'b0, 5'h0, 32'h0, 32'h0, 16'h0, 5'h0);
      repeat (2) @(negedge clk);
      check_eq("rst_valid", 32'(MEM_valid), 32'd0);
      check_eq("rst_result", MEM_result, 32'h0);
      check_eq("rst_store", MEM_store_data, 32'h0);
      check_eq("rst_sideband", 32'(mem_sb), 32'd0);
      check_eq("rst_stall", 32'(EX_stall), 32'd0);
      rst_n = 1'b1;

      // back-to-back single-cycle ops, first one on the first edge after reset
      for (int i = 0; i < 10; i++) begin
         sb_i = 5'(i) ^ 5'h15;
         drive(1'b1, sc_op[i], sc_a[i], sc_b[i], sc_imm[i], sb_i);
         #1;
         check_eq($sformatf("sc%0d_stall", i), 32'(EX_stall), 32'd0);
         @(negedge clk);
         check_eq($sformatf("sc%0d_valid", i), 32'(MEM_valid), 32'd1);
         check_eq($sformatf("sc%0d_result", i), MEM_result, sc_exp[i]);
         check_eq($sformatf("sc%0d_store", i), MEM_store_data, sc_b[i]);
         check_eq($sformatf("sc%0d_sideband", i), 32'(mem_sb), 32'(sb_i));
      end
      drive(1'b0, 5'h0, 32'h0, 32'h0, 16'h0, 5'h0);
      @(negedge clk);
      check_eq("idle_valid_low", 32'(MEM_valid), 32'd0);
      check_eq("idle_result_held", MEM_result, 32'h20);
      check_eq("idle_no_stall", 32'(EX_stall), 32'd0);

      // MULU, then an ADD presented during DONE must wait for IDLE
      run_multi("mulu", 5'h10, 32'h00010000, 32'h00010001, 5'b10110, 32'h00010000);
      drive(1'b1, 5'h00, 32'h2, 32'h3, 16'h0, 5'h0);
      @(negedge clk);
      check_eq("done_ignores_valid", 32'(MEM_valid), 32'd0);
      check_eq("done_result_held", MEM_result, 32'h00010000);
      @(negedge clk);
      check_eq("after_done_add_valid", 32'(MEM_valid), 32'd1);
      check_eq("after_done_add_result", MEM_result, 32'h5);
      drive(1'b0, 5'h0, 32'h0, 32'h0, 16'h0, 5'h0);
      @(negedge clk);

      // reset at iteration 10 of a MULU
      drive(1'b1, 5'h10, 32'h3, 32'h5, 16'h0, 5'h1F);
      repeat (11) @(negedge clk);
      check_eq("mid_iter_stall", 32'(EX_stall), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_valid", 32'(MEM_valid), 32'd0);
      check_eq("midrst_result", MEM_result, 32'h0);
      check_eq("midrst_store", MEM_store_data, 32'h0);
      check_eq("midrst_sideband", 32'(mem_sb), 32'd0);
      check_eq("midrst_stall", 32'(EX_stall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 5'h08, 32'h4, 32'h0, 16'hFFFF, 5'h0);
      #1;
      check_eq("addi_stall", 32'(EX_stall), 32'd0);
      @(negedge clk);
      check_eq("addi_valid", 32'(MEM_valid), 32'd1);
      check_eq("addi_result", MEM_result, 32'h3);
      drive(1'b0, 5'h0, 32'h0, 32'h0, 16'h0, 5'h0);
      pulses = 0;
      repeat (36) begin
         @(negedge clk);
         pulses += 32'(MEM_valid);
      end
      check_eq("discarded_op_pulses", 32'(pulses), 32'd0);

`ifdef EX_MULDIV_DIVIDER_EN
      run_multi("divu", 5'h11, 32'd100, 32'd7, 5'b01010, 32'd14);
      drive(1'b1, 5'h12, 32'd100, 32'd7, 16'h0, 5'b00101);
      @(negedge clk);
      check_eq("div_no_double_accept", 32'(MEM_valid), 32'd0);
      run_multi("remu", 5'h12, 32'd100, 32'd7, 5'b00101, 32'd2);
      drive(1'b0, 5'h0, 32'h0, 32'h0, 16'h0, 5'h0);
      @(negedge clk);
      check_eq("remu_single_pulse", 32'(MEM_valid), 32'd0);
      run_multi("divu_by0", 5'h11, 32'd5, 32'd0, 5'b10001, 32'hFFFFFFFF);
      drive(1'b0, 5'h0, 32'h0, 32'h0, 16'h0, 5'h0);
      @(negedge clk);
      run_multi("remu_by0", 5'h12, 32'd5, 32'd0, 5'b01110, 32'd5);
      drive(1'b0, 5'h0, 32'h0, 32'h0, 16'h0, 5'h0);
      @(negedge clk);
`else
      drive(1'b1, 5'h11, 32'd100, 32'd7, 16'h0, 5'b01010);
      #1;
      check_eq("nodiv_divu_stall", 32'(EX_stall), 32'd0);
      @(negedge clk);
      check_eq("nodiv_divu_valid", 32'(MEM_valid), 32'd1);
      check_eq("nodiv_divu_result", MEM_result, 32'h0);
      drive(1'b1, 5'h12, 32'd100, 32'd7, 16'h0, 5'b00101);
      #1;
      check_eq("nodiv_remu_stall", 32'(EX_stall), 32'd0);
      @(negedge clk);
      check_eq("nodiv_remu_valid", 32'(MEM_valid), 32'd1);
      check_eq("nodiv_remu_result", MEM_result, 32'h0);
      drive(1'b0, 5'h0, 32'h0, 32'h0, 16'h0, 5'h0);
      @(negedge clk);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port EX_valid, input, 1 bit: ID/EX bundle holds a live instruction.
REQ-004 SHALL have port EX_ALU_OP, input, 5 bits: operation code.
REQ-005 SHALL have ports EX_muxA and EX_muxB, input, 32 bits each: operands A and B.
REQ-006 SHALL have port EX_IMMEDIATE, input, 16 bits: signed immediate.
REQ-007 SHALL have sideband inputs EX_ret_enable (1), EX_RF_D_SEL (2), EX_DM_WE (1) and EX_DM_ADDR_SEL (1), carried unchanged to MEM.
REQ-008 SHALL have port EX_stall, output, 1 bit: ID must hold the bundle stable while high.
REQ-009 SHALL have port MEM_valid, output, 1 bit: result bundle valid, one-cycle pulse per instruction.
REQ-010 SHALL have port MEM_result, output, 32 bits, and MEM_store_data, output, 32 bits (captured B).
REQ-011 SHALL have outputs MEM_ret_enable, MEM_RF_D_SEL, MEM_DM_WE and MEM_DM_ADDR_SEL, with the same widths as the matching inputs.

Function
REQ-012 SHALL decode op codes as follows: 0x00 ADD, 0x01 SUB (A-B), 0x02 AND, 0x03 OR, 0x04 XOR, 0x05 SLL (A<<B[4:0]), 0x06 SRL, 0x08 ADDI (A+sext(imm)), 0x10 MULU, 0x11 DIVU, 0x12 REMU; every other code SHALL give result 0 and complete in a single cycle.
REQ-013 SHALL implement a state machine with states IDLE, ITER and DONE.
REQ-014 SHALL, in IDLE with EX_valid=1 and a single-cycle op, register the result and sideband at that edge, raise MEM_valid for the next cycle and remain in IDLE; back-to-back single-cycle ops SHALL sustain one per cycle.
REQ-015 SHALL, in IDLE with EX_valid=1 and a multi-cycle op (0x10-0x12), drive EX_stall=1 combinationally in that same cycle, capture operands and sideband at the edge, clear the 5-bit counter and enter ITER.
REQ-016 SHALL hold EX_stall=1 throughout ITER and perform one shift-add (MULU) or restoring-subtract (DIVU/REMU) step per edge, incrementing the counter.
REQ-017 SHALL, at the ITER edge where counter==31, write MEM outputs and enter DONE; MEM_valid SHALL therefore be high exactly 32 cycles after the accept edge.
REQ-018 SHALL drive EX_stall=0 in DONE, ignore all inputs in DONE (they still carry the already-accepted instruction) and return to IDLE on the next edge.
REQ-019 SHALL make MULU return the low 32 bits of the unsigned product, DIVU the unsigned quotient and REMU the unsigned remainder.
REQ-020 SHALL, for a divisor of 0, return quotient 0xFFFFFFFF and remainder equal to A, taking the full 32-iteration latency.
REQ-021 SHALL keep MEM_valid=0 whenever no result is being presented; the MEM data outputs SHALL hold their last values while MEM_valid=0.
REQ-022 SHALL ignore EX_valid=0 in IDLE: no state change, no stall.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-ITER, force the state to IDLE, the counter and datapath registers to 0, every MEM_* output to 0 and EX_stall to 0; any in-flight operation SHALL be discarded.
REQ-024 SHALL accept its first instruction on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL, when macro EX_MULDIV_DIVIDER_EN is defined, implement DIVU and REMU as specified above.
REQ-026 SHALL, when EX_MULDIV_DIVIDER_EN is undefined, treat 0x11 and 0x12 as single-cycle ops returning 0 with no stall and no divider logic; MULU SHALL be unaffected.

Verification
REQ-027 SHALL cover ADD with A=0x7FFFFFFF, B=1 -> MEM_valid the next cycle, MEM_result=0x80000000, EX_stall never high.
REQ-028 SHALL cover MULU with A=0x10000, B=0x10001 -> EX_stall high for 33 cycles, MEM_valid 32 cycles after accept, MEM_result=0x00010000.
REQ-029 SHALL cover DIVU 100/7 followed by REMU 100/7 -> MEM_result=14 then 2, each one MEM_valid pulse, no double acceptance in DONE.
REQ-030 SHALL cover DIVU with A=5, B=0 -> MEM_result=0xFFFFFFFF; REMU with A=5, B=0 -> MEM_result=5.
REQ-031 SHALL cover rst_n pulsed low at iteration 10 of a MULU -> all outputs 0, state IDLE, and an ADDI with A=4, imm=0xFFFF issued after reset -> MEM_result=3.
REQ-032 SHALL cover a build without EX_MULDIV_DIVIDER_EN: DIVU 100/7 -> MEM_result=0 the next cycle, EX_stall=0.
